// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel time-setting controller:
// state encoding, field limits, blink field indices and wrap helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } state_t;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  localparam int unsigned FLD_HOUR = 2;
  localparam int unsigned FLD_MIN  = 1;
  localparam int unsigned FLD_SEC  = 0;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  function automatic logic [5:0] clamp_field(input logic [5:0] v, input logic [5:0] max);
    return (v > max) ? 6'd0 : v;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability counter,
// one-cycle press pulse and optional hold-to-repeat.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DLY   = 50_000_000,
  parameter int unsigned REPEAT_PER   = 12_500_000,
  parameter bit          REPEAT_EN    = 1'b0
) (
  input  logic clk50,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int unsigned RW = $clog2(REPEAT_DLY + REPEAT_PER) + 1;

  logic          sync1, sync2;
  logic          level;
  logic          raw_pressed;
  logic [DW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          repeating;

  assign raw_pressed = ~sync2;

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      level     <= 1'b0;
      cnt       <= '0;
      rcnt      <= '0;
      repeating <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;

      if (raw_pressed != level) begin
        if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
          level <= raw_pressed;
          cnt   <= '0;
          if (raw_pressed) press <= 1'b1;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end

      // Repeats run only while the synchronized key is still down, so a
      // release in progress never emits a trailing repeat.
      if (REPEAT_EN && level && raw_pressed) begin
        if (!repeating && rcnt == RW'(REPEAT_DLY - 1)) begin
          press     <= 1'b1;
          repeating <= 1'b1;
          rcnt      <= '0;
        end else if (repeating && rcnt == RW'(REPEAT_PER - 1)) begin
          press <= 1'b1;
          rcnt  <= '0;
        end else begin
          rcnt <= rcnt + RW'(1);
        end
      end else begin
        rcnt      <= '0;
        repeating <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel time-setting controller: RUN->SET_H->SET_M->SET_S sequencing,
// shadow time editing, commit strobe, blink mask and edit timeout.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DLY   = 50_000_000,
  parameter int unsigned REPEAT_PER   = 12_500_000,
  parameter int unsigned BLINK_HALF   = 12_500_000,
  parameter int unsigned TIMEOUT_CYC  = 500_000_000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [5:0] hour_set,
  output logic [5:0] min_set,
  output logic [5:0] sec_set,
  output logic       load,
  output logic       run_en,
  output logic [2:0] blink_mask,
  output logic [1:0] mode
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned BW = $clog2(BLINK_HALF) + 1;

  state_t        state, state_nx;
  logic          ev_mode, ev_inc, ev_dec, any_ev;
  logic          edit_ok, timeout_hit;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic          phase;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DLY(REPEAT_DLY),
                 .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b0))
    u_mode (.clk50(clk50), .reset(reset), .key_n(key_mode), .press(ev_mode));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DLY(REPEAT_DLY),
                 .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1))
    u_inc (.clk50(clk50), .reset(reset), .key_n(key_inc), .press(ev_inc));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DLY(REPEAT_DLY),
                 .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1))
    u_dec (.clk50(clk50), .reset(reset), .key_n(key_dec), .press(ev_dec));

  assign any_ev      = ev_mode | ev_inc | ev_dec;
  assign edit_ok     = !ev_mode && (ev_inc ^ ev_dec);
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state != RUN && !any_ev && timeout_hit) begin
      state_nx = RUN;
    end else if (ev_mode) begin
      case (state)
        RUN:     state_nx = SET_H;
        SET_H:   state_nx = SET_M;
        SET_M:   state_nx = SET_S;
        default: state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    mode       = state;
    run_en     = (state == RUN);
    blink_mask = '0;
    case (state)
      SET_H:   blink_mask[FLD_HOUR] = phase;
      SET_M:   blink_mask[FLD_MIN]  = phase;
      SET_S:   blink_mask[FLD_SEC]  = phase;
      default: blink_mask = '0;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      hour_set <= '0;
      min_set  <= '0;
      sec_set  <= '0;
      load     <= 1'b0;
    end else begin
      load <= (state == SET_S) && ev_mode;
      if (state == RUN) begin
        if (ev_mode) begin
          hour_set <= clamp_field(cur_hour, HOUR_MAX);
          min_set  <= clamp_field(cur_min, MIN_MAX);
          sec_set  <= clamp_field(cur_sec, SEC_MAX);
        end
      end else if (edit_ok) begin
        case (state)
          SET_H:   hour_set <= ev_inc ? wrap_inc(hour_set, HOUR_MAX) : wrap_dec(hour_set, HOUR_MAX);
          SET_M:   min_set  <= ev_inc ? wrap_inc(min_set, MIN_MAX)   : wrap_dec(min_set, MIN_MAX);
          SET_S:   sec_set  <= ev_inc ? wrap_inc(sec_set, SEC_MAX)   : wrap_dec(sec_set, SEC_MAX);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (state == RUN || any_ev || timeout_hit) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Any inc/dec press (even a cancelled inc+dec pair) shows the field solid.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (state == RUN || ev_inc || ev_dec) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_HALF - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: key schedules are turned into expected press
// events arithmetically, then an event-level model predicts every output.
module tb_clock_set_ctrl;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int BH   = 8;
  localparam int TO   = 200;
  localparam int MAXE = 6100;
  localparam int NE1  = 6000;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic       key_mode = 1'b1, key_inc = 1'b1, key_dec = 1'b1;
  logic [5:0] cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic [5:0] hour_set, min_set, sec_set;
  logic       load, run_en;
  logic [2:0] blink_mask;
  logic [1:0] mode;

  clock_set_ctrl #(
    .DEBOUNCE_CYC(D), .REPEAT_DLY(RD), .REPEAT_PER(RP),
    .BLINK_HALF(BH), .TIMEOUT_CYC(TO)
  ) dut (
    .clk50(clk50), .reset(reset),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set),
    .load(load), .run_en(run_en), .blink_mask(blink_mask), .mode(mode)
  );

  always #5 clk50 = ~clk50;

  // key index: 0 mode, 1 inc, 2 dec; kv[k][n] is the key level before edge n
  bit kv [3][0:MAXE];
  bit ev [3][0:MAXE];
  int ch [0:MAXE];
  int cm [0:MAXE];
  int cs [0:MAXE];

  int n_cmp = 0;
  int n_bad = 0;
  int st, hs, ms, ss, ld, last_act, blink_base;

  task automatic chk(input string nm, input int n, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", nm, n, got, want);
    end
  endtask

  task automatic clear_sched();
    for (int k = 0; k < 3; k++)
      for (int n = 0; n <= MAXE; n++) begin
        kv[k][n] = 1'b1;
        ev[k][n] = 1'b0;
      end
    for (int n = 0; n <= MAXE; n++) begin
      ch[n] = 0; cm[n] = 0; cs[n] = 0;
    end
  endtask

  task automatic hold(input int k, input int a, input int len);
    for (int i = a; i < a + len; i++) kv[k][i] = 1'b0;
  endtask

  task automatic set_cur(input int from, input int to, input int h, input int m, input int s);
    for (int n = from; n <= to; n++) begin
      ch[n] = h; cm[n] = m; cs[n] = s;
    end
  endtask

  // A low run starting at edge a of length len yields a press after edge
  // a+D+1, then repeats at +RD and every RP while the key is still down.
  task automatic derive_events(input int ne);
    for (int k = 0; k < 3; k++)
      for (int a = 1; a <= ne; a++)
        if (kv[k][a] == 1'b0 && kv[k][a-1] == 1'b1) begin
          int len = 0;
          while (a + len <= MAXE && kv[k][a+len] == 1'b0) len++;
          if (len >= D) begin
            if (a + D + 1 <= ne) ev[k][a+D+1] = 1'b1;
            if (k != 0)
              for (int t = a + D + 1 + RD; t <= a + len + 1 && t <= ne; t += RP)
                ev[k][t] = 1'b1;
          end
        end
  endtask

  function automatic int clampv(input int v, input int max);
    return (v > max) ? 0 : v;
  endfunction

  task automatic model_step(input int n);
    bit em, ei, ed;
    int dl;
    em = ev[0][n-1]; ei = ev[1][n-1]; ed = ev[2][n-1];
    ld = 0;
    if (st == 0) begin
      if (em) begin
        hs = clampv(ch[n], 23); ms = clampv(cm[n], 59); ss = clampv(cs[n], 59);
        st = 1; last_act = n; blink_base = n;
      end
    end else begin
      if (em || ei || ed) last_act = n;
      if (ei || ed) blink_base = n;
      if (em) begin
        if (st == 3) begin st = 0; ld = 1; end
        else st = st + 1;
      end else if (ei ^ ed) begin
        dl = ei ? 1 : -1;
        case (st)
          1: hs = (hs + 24 + dl) % 24;
          2: ms = (ms + 60 + dl) % 60;
          default: ss = (ss + 60 + dl) % 60;
        endcase
      end else if (n - last_act == TO) begin
        st = 0;
      end
    end
  endtask

  task automatic compare(input int n);
    int eb;
    eb = 0;
    if (st != 0 && ((n - blink_base) / BH) % 2 == 1) eb = 1 << (3 - st);
    chk("mode", n, mode, st);
    chk("run_en", n, run_en, (st == 0) ? 1 : 0);
    chk("load", n, load, ld);
    chk("hour_set", n, hour_set, hs);
    chk("min_set", n, min_set, ms);
    chk("sec_set", n, sec_set, ss);
    chk("blink_mask", n, blink_mask, eb);
  endtask

  task automatic literal(input int n);
    case (n)
      16: begin
        chk("lit_mode", n, mode, 1);      chk("lit_hour", n, hour_set, 12);
        chk("lit_min", n, min_set, 34);   chk("lit_sec", n, sec_set, 56);
        chk("lit_run_en", n, run_en, 0);  chk("lit_blink", n, blink_mask, 0);
      end
      24:  chk("lit_blink", n, blink_mask, 4);
      32:  chk("lit_blink", n, blink_mask, 0);
      60:  chk("lit_glitch_hour", n, hour_set, 12);
      65:  chk("lit_hour", n, hour_set, 12);
      66:  chk("lit_hour", n, hour_set, 13);
      85:  chk("lit_hour", n, hour_set, 13);
      86:  chk("lit_rep_hour", n, hour_set, 14);
      100: chk("lit_rep_hour", n, hour_set, 16);
      101: chk("lit_rep_hour", n, hour_set, 17);
      200: chk("lit_hour", n, hour_set, 23);
      210: chk("lit_hour_wrap", n, hour_set, 0);
      221: begin chk("lit_mode", n, mode, 2); chk("lit_min", n, min_set, 34); end
      423: chk("lit_min", n, min_set, 0);
      430: chk("lit_min_wrap", n, min_set, 59);
      446: chk("lit_mode", n, mode, 3);
      495: chk("lit_sec", n, sec_set, 59);
      510: chk("lit_sec_wrap", n, sec_set, 0);
      525: chk("lit_incdec", n, sec_set, 0);
      536: begin
        chk("lit_mode", n, mode, 0);     chk("lit_load", n, load, 1);
        chk("lit_run_en", n, run_en, 1); chk("lit_hour", n, hour_set, 0);
        chk("lit_min", n, min_set, 59);  chk("lit_sec", n, sec_set, 0);
      end
      537: chk("lit_load", n, load, 0);
      556: begin
        chk("lit_mode", n, mode, 1);     chk("lit_clamp_hour", n, hour_set, 0);
        chk("lit_min", n, min_set, 45);  chk("lit_sec", n, sec_set, 7);
      end
      775: chk("lit_mode", n, mode, 2);
      776: begin
        chk("lit_to_mode", n, mode, 0);  chk("lit_to_run_en", n, run_en, 1);
        chk("lit_to_load", n, load, 0);  chk("lit_to_hour", n, hour_set, 0);
        chk("lit_to_min", n, min_set, 45); chk("lit_to_sec", n, sec_set, 7);
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b0;
    key_mode = 1'b1; key_inc = 1'b1; key_dec = 1'b1;
    repeat (3) @(negedge clk50);
    reset = 1'b1;
  endtask

  task automatic run(input int ne, input bit lit);
    st = 0; hs = 0; ms = 0; ss = 0; ld = 0; last_act = 0; blink_base = 0;
    compare(0);
    for (int n = 1; n <= ne; n++) begin
      key_mode = kv[0][n]; key_inc = kv[1][n]; key_dec = kv[2][n];
      cur_hour = 6'(ch[n]); cur_min = 6'(cm[n]); cur_sec = 6'(cs[n]);
      @(posedge clk50);
      model_step(n);
      @(negedge clk50);
      compare(n);
      if (lit) literal(n);
    end
  endtask

  initial begin
    int pos, len, gap, r, q;

    // Phase 1: directed edit sequence followed by random key traffic
    clear_sched();
    set_cur(1, 539, 12, 34, 56);
    set_cur(540, 799, 30, 45, 7);
    for (int n = 800; n <= MAXE; n++) begin
      ch[n] = $urandom_range(0, 31);
      cm[n] = $urandom_range(0, 63);
      cs[n] = $urandom_range(0, 63);
    end
    hold(0, 10, 8);
    hold(1, 40, 3);
    hold(1, 60, 40);
    for (int k = 0; k < 6; k++) hold(1, 110 + 15 * k, 6);
    hold(1, 200, 6);
    hold(0, 215, 6);
    hold(2, 235, 189);
    hold(0, 440, 6);
    for (int k = 0; k < 4; k++) hold(1, 455 + 15 * k, 6);
    hold(1, 515, 6);
    hold(2, 515, 6);
    hold(0, 530, 6);
    hold(0, 550, 6);
    hold(0, 570, 6);

    pos = 800;
    while (pos < NE1 - 200) begin
      r = $urandom_range(0, 9);
      q = $urandom_range(0, 9);
      if (q < 2)      len = $urandom_range(1, D - 1);
      else if (q < 7) len = $urandom_range(D, 12);
      else            len = $urandom_range(24, 70);
      if (r < 3)       hold(0, pos, len);
      else if (r < 6)  hold(1, pos, len);
      else if (r < 8)  hold(2, pos, len);
      else if (r == 8) begin hold(1, pos, len); hold(2, pos, len); end
      else begin
        hold(0, pos, len);
        hold(($urandom_range(0, 1) == 0) ? 1 : 2, pos, len);
      end
      gap = ($urandom_range(0, 14) == 0) ? $urandom_range(150, 260) : $urandom_range(6, 40);
      pos = pos + len + gap;
    end
    derive_events(NE1);
    do_reset();
    run(NE1, 1'b1);

    // Phase 2: walk into SET_S, then reset asynchronously between edges
    clear_sched();
    set_cur(1, 70, 12, 34, 56);
    hold(0, 10, 6);
    hold(0, 30, 6);
    hold(0, 50, 6);
    derive_events(70);
    do_reset();
    run(70, 1'b0);
    chk("pre_rst_mode", 70, mode, 3);
    chk("pre_rst_hour", 70, hour_set, 12);
    #2 reset = 1'b0;
    #1;
    chk("rst_mode", -1, mode, 0);
    chk("rst_run_en", -1, run_en, 1);
    chk("rst_load", -1, load, 0);
    chk("rst_hour", -1, hour_set, 0);
    chk("rst_min", -1, min_set, 0);
    chk("rst_sec", -1, sec_set, 0);
    chk("rst_blink", -1, blink_mask, 0);
    @(negedge clk50);
    reset = 1'b1;
    clear_sched();
    derive_events(40);
    run(40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
